// File: rtl/ect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ect_pkg
//  Description : Shared definitions for the eddy-current excitation and
//                receive paths: ADC code format, sampling state encoding and
//                the sampling-window test.
//  Revision    : 1.0 - initial release
// ============================================================================
package ect_pkg;

    // ADC sample width and the offset-binary code that represents zero
    localparam int                ADC_W     = 14;
    localparam logic [ADC_W-1:0]  ZERO_CODE = 14'h2000;

    // Sampling state encoding, shared with the excitation-side counter
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    // Window test done in 9 bits so start + num cannot wrap past 255
    function automatic logic in_window(
        input logic [7:0] pcnt,
        input logic [7:0] start,
        input logic [7:0] num
    );
        logic [8:0] w_pc;
        logic [8:0] w_lo;
        logic [8:0] w_hi;
        begin
            w_pc = {1'b0, pcnt};
            w_lo = {1'b0, start};
            w_hi = {1'b0, start} + {1'b0, num};
            in_window = (w_pc >= w_lo) && (w_pc < w_hi);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ect_sample_accum_ob2tc.sv
`default_nettype none
// ============================================================================
//  Module      : ob2tc
//  Description : Offset-binary ADC code to sign-extended two's complement.
//                Flipping the MSB (XOR with the zero code) re-centres the
//                code on zero; the result is then sign-extended to OUT_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module ob2tc
    import ect_pkg::*;
#(
    parameter int OUT_W = 32
)(
    input  logic [ADC_W-1:0]        i_code,
    output logic signed [OUT_W-1:0] o_value
);

    logic [ADC_W-1:0] w_tc;

    // Re-centre the offset-binary code: 0x2000 -> 0, 0x3FFF -> +8191, 0x0000 -> -8192
    assign w_tc = i_code ^ ZERO_CODE;

    generate
        if (OUT_W > ADC_W) begin : g_extend
            assign o_value = {{(OUT_W-ADC_W){w_tc[ADC_W-1]}}, w_tc};
        end else begin : g_direct
            assign o_value = w_tc[OUT_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ect_sample_accum.sv
`default_nettype none
// ============================================================================
//  Module      : ect_sample_accum
//  Description : Receive-side sample accumulator. Sums ADC samples while the
//                excitation period index lies inside the sampling window and
//                hands one result per switch cycle to the readout over a
//                valid/ready handshake, flagging overwritten results.
//  Revision    : 1.0 - initial release
// ============================================================================
module ect_sample_accum
    import ect_pkg::*;
#(
    parameter logic [7:0] SampleStart = 8'd2,
    parameter logic [7:0] SampleNum   = 8'd4,
    parameter int         AccW        = 32,
    parameter int         CntW        = 16
)(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EnExcit,
    input  logic [7:0]        periodCnt,
    input  logic [ADC_W-1:0]  AdcData,
    input  logic              AdcValid,
    output logic [AccW-1:0]   Result,
    output logic [CntW-1:0]   ResCnt,
    output logic              ResValid,
    input  logic              ResReady,
    output logic              Overrun
);

    // ------------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [AccW-1:0]    r_acc;
    logic [CntW-1:0]    r_cnt;
    logic               r_en_d;

    logic               w_inwin;
    logic [AccW-1:0]    w_sample;
    logic               w_cnt_full;
    logic               w_load;
    logic               w_en_rise;
    logic               w_accept;

    // ------------------------------------------------------------------------
    // Sample conversion
    // ------------------------------------------------------------------------
    ob2tc #(
        .OUT_W (AccW)
    ) u_ob2tc (
        .i_code  (AdcData),
        .o_value (w_sample)
    );

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    assign w_inwin    = in_window(periodCnt, SampleStart, SampleNum);
    assign w_cnt_full = &r_cnt;

    // A window closes on the first out-of-window cycle while accumulating;
    // an excitation drop in that same cycle takes precedence and discards it.
    assign w_load     = (r_state == ST_ACCUM) && EnExcit && !w_inwin;
    assign w_en_rise  = EnExcit && !r_en_d;
    assign w_accept   = ResValid && ResReady;

    // Previous excitation enable, used to find 0->1 transitions
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= EnExcit;
        end
    end

    // Sampling state machine with accumulator and sample counter
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (!EnExcit) begin
            // Excitation stopped: drop any partial window without a result
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_WAIT;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end

                ST_WAIT: begin
                    if (w_inwin) begin
                        // Window entry cycle: its sample already counts
                        r_state <= ST_ACCUM;
                        if (AdcValid) begin
                            r_acc <= w_sample;
                            r_cnt <= CntW'(1);
                        end else begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end
                    end else begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end

                ST_ACCUM: begin
                    if (!w_inwin) begin
                        // Exit cycle: sum is handed over, this cycle's sample is dropped
                        r_state <= ST_WAIT;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (AdcValid && !w_cnt_full) begin
                        // Saturated counter freezes both the count and the sum
                        r_acc <= r_acc + w_sample;
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Result register, valid/ready handshake and sticky overrun flag
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Result   <= '0;
            ResCnt   <= '0;
            ResValid <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                Result   <= r_acc;
                ResCnt   <= r_cnt;
                ResValid <= 1'b1;
                // Only an unconsumed result being replaced counts as overrun
                if (ResValid && !ResReady) begin
                    Overrun <= 1'b1;
                end
            end else if (w_accept) begin
                ResValid <= 1'b0;
            end

            // Re-enabling excitation starts a fresh measurement run
            if (w_en_rise) begin
                Overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ect_sample_accum.md
# ect_sample_accum

Receive-side counterpart of the excitation hold-zero period counter. It consumes the excitation period index `periodCnt` and the ADC sample stream. It accumulates offset-binary ADC samples only while `periodCnt` is inside the sampling window, and hands one accumulated result per switch cycle to the readout logic over a valid/ready handshake. It sits between the ADC capture register and the demodulation/readout FIFO.

## Interface
- `SampleStart`, default 8'd2: first `periodCnt` value of the sampling window.
- `SampleNum`, default 8'd4: number of consecutive `periodCnt` values in the window.
- `AccW`, default 32: accumulator and result width.
- `CntW`, default 16: sample-counter width.
- `Clk` input, 1 bit: system clock. All logic runs on its rising edge.
- `Rst` input, 1 bit: asynchronous, active-low reset.
- `EnExcit` input, 1 bit: excitation enable, synchronous to `Clk`.
- `periodCnt` input, 8 bits: excitation period index, synchronous to `Clk`.
- `AdcData` input, 14 bits: ADC sample, offset binary. 14'h2000 is zero.
- `AdcValid` input, 1 bit: one-cycle strobe that qualifies `AdcData`.
- `Result` output, `AccW` bits: signed sum of the window's samples.
- `ResCnt` output, `CntW` bits: number of samples summed into `Result`.
- `ResValid` output, 1 bit: result available.
- `ResReady` input, 1 bit: consumer accepts the result.
- `Overrun` output, 1 bit: sticky flag. Set when an unconsumed result was overwritten.

## Operation
- InWin = (`periodCnt` >= `SampleStart`) && (`periodCnt` < `SampleStart` + `SampleNum`). The comparison uses 9-bit arithmetic so the upper bound cannot wrap.
- Sample conversion: invert `AdcData`[13], then sign-extend the result to `AccW` bits as two's complement. 14'h2000 becomes 0, 14'h3FFF becomes +8191, 14'h0000 becomes -8192.
- State machine:
  - IDLE: entered from reset and whenever `EnExcit`=0. Acc=0, Cnt=0. Goes to WAIT when `EnExcit`=1.
  - WAIT: Acc=0, Cnt=0. Goes to ACCUM when InWin=1. A sample with `AdcValid` in that same cycle is accumulated.
  - ACCUM: when `AdcValid`=1, Acc += sample and Cnt += 1.
    - When Cnt reaches its maximum (all ones), further samples are ignored; Acc does not change.
    - When InWin=0 (including `periodCnt` wrapping to 0), Acc and Cnt are loaded into `Result` and `ResCnt`, `ResValid` is set, and the state goes to WAIT. A sample arriving in this exit cycle is not counted.
- `EnExcit`=0 in any state: go to IDLE and discard any partial sum. No result is produced. `ResValid`, `Result` and `ResCnt` are unaffected.
- Handshake: once set, `ResValid` holds until a cycle with `ResValid` && `ResReady`. It clears on the next edge.
- Result load while `ResValid`=1 and `ResReady`=0: the new result overwrites the old one, `ResValid` stays 1, and `Overrun` is set.
- Result load while `ResValid` && `ResReady`: the old result is consumed, the new one is loaded, `ResValid` stays 1, and `Overrun` is unchanged.
- `Overrun` clears on reset or on an `EnExcit` 0→1 transition.

## Timing
- Reset values: state IDLE, Acc=0, Cnt=0, `Result`=0, `ResCnt`=0, `ResValid`=0, `Overrun`=0.
- Sample latency: a sample at edge N is reflected in Acc after edge N.
- Result latency: in the first cycle N with `periodCnt` outside the window during ACCUM, `Result`, `ResCnt` and `ResValid` are valid from edge N+1.
- Throughput: one result per excitation switch cycle. There is no minimum gap between consecutive windows.
- Reset mid-window: all state clears immediately (asynchronous). No partial result is emitted.

## Structure
- Shared package `ect_pkg` holds:
  - the `ZERO_CODE` constant, 14'h2000;
  - the ADC width, 14;
  - the state encoding IDLE/WAIT/ACCUM.
- The excitation-side counter uses the same package.
- One sub-module, `ob2tc`: offset-binary to sign-extended two's complement conversion. It is combinational and parameterised by output width. All remaining logic is a single module.

## Test plan
- Basic window:
  - Stimulus: `EnExcit`=1; `periodCnt` steps 0..9 with 10 cycles per step; `AdcValid` every 2nd cycle; `AdcData`=14'h2005.
  - Required: 20 samples, `Result`=100, `ResCnt`=20. `ResValid` rises one cycle after `periodCnt` becomes 6.
- Sign handling:
  - Stimulus: samples 14'h0000 and 14'h3FFF alternating, 8 total.
  - Required: `Result`=-4 (4×(-8192)+4×8191), `ResCnt`=8.
- Abort:
  - Stimulus: drop `EnExcit` while `periodCnt`=4 with samples pending.
  - Required: no `ResValid`; the next full window sums only its own samples.
- Overrun:
  - Stimulus: hold `ResReady`=0 across two switch cycles.
  - Required: second result replaces the first, `Overrun`=1, `ResValid`=1. `Overrun` clears after an `EnExcit` 0→1 toggle.
- Simultaneous accept and load:
  - Stimulus: `ResReady`=1 in the exact cycle a new result loads.
  - Required: `ResValid` stays 1, the new `Result` is visible, `Overrun`=0.
- Boundary and reset:
  - Stimulus 1: `AdcValid` in the entry cycle (`periodCnt` 1→2) and in the exit cycle (5→6).
  - Required: the entry sample is counted; the exit sample is not.
  - Stimulus 2: assert `Rst` mid-ACCUM.
  - Required: all outputs return to 0 immediately.
